// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
package instr_fetch_unit_pkg;

  localparam int                  WORD_W        = 32;
  localparam int                  ADDR_BITS_DEF = 10;
  localparam logic [WORD_W-1:0]   PC_INC        = 32'd4;
  localparam logic [WORD_W-1:0]   PC_RESET      = 32'h0000_0000;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit_if.sv
// Control/decode-facing bus of the fetch unit: next-PC controls in, PC and instruction out.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic [WORD_W-1:0] PC_Immed;
  logic              PC_Sel;
  logic              PC_LdEn;
  logic [WORD_W-1:0] Instr;
  logic [WORD_W-1:0] PC;

  // Control unit / decode side
  modport master (
    output PC_Immed,
    output PC_Sel,
    output PC_LdEn,
    input  Instr,
    input  PC
  );

  // Fetch unit side
  modport slave (
    input  PC_Immed,
    input  PC_Sel,
    input  PC_LdEn,
    output Instr,
    output PC
  );

endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit_rom.sv
// Read-only instruction memory with a registered, asynchronously cleared output word.
module instr_rom
  import instr_fetch_unit_pkg::*;
#(
  parameter int    ADDR_BITS = ADDR_BITS_DEF,
  parameter string INIT_FILE = "rom.data"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr,
  output logic [WORD_W-1:0]    dout
);

  logic [WORD_W-1:0] mem [0:(2**ADDR_BITS)-1];
  logic [WORD_W-1:0] dout_d;
  logic [WORD_W-1:0] dout_q;

  // Combinational read of the addressed word
  always_comb begin
    dout_d = mem[addr];
  end

  // Output register, cleared by reset so the decode stage sees a zero word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= {WORD_W{1'b0}};
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule : instr_rom

// File: rtl/instr_fetch_unit_sel_mux.sv
// Generic 2^SEL-way selector over a flattened input bus; entry i sits at [i*BUS_WIDTH +: BUS_WIDTH].
module sel_mux #(
  parameter int BUS_WIDTH = 32,
  parameter int SEL       = 1
) (
  input  logic [(2**SEL)*BUS_WIDTH-1:0] Din,
  input  logic [SEL-1:0]                Sel,
  output logic [BUS_WIDTH-1:0]          Dout
);

  // Pick the entry addressed by Sel
  always_comb begin
    Dout = Din[Sel*BUS_WIDTH +: BUS_WIDTH];
  end

endmodule : sel_mux

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC register, sequential/branch next-PC selection, and registered ROM read.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int    ADDR_BITS = ADDR_BITS_DEF,
  parameter string INIT_FILE = "rom.data"
) (
  input  logic         Clk,
  input  logic         Reset,
  instr_fetch_unit_if.slave bus
);

  logic [WORD_W-1:0]   pc_q;
  logic [WORD_W-1:0]   pc_d;
  logic [WORD_W-1:0]   pc_seq_s;
  logic [WORD_W-1:0]   pc_br_s;
  logic [WORD_W-1:0]   pc_mux_s;
  logic [2*WORD_W-1:0] pc_cand_s;
  logic [WORD_W-1:0]   instr_s;

  // Next-PC candidates; all arithmetic wraps modulo 2^32
  always_comb begin
    pc_seq_s  = pc_q + PC_INC;
    pc_br_s   = pc_seq_s + bus.PC_Immed;
    pc_cand_s = {pc_br_s, pc_seq_s};
  end

  sel_mux #(
    .BUS_WIDTH (WORD_W),
    .SEL       (1)
  ) u_pc_mux (
    .Din  (pc_cand_s),
    .Sel  (bus.PC_Sel),
    .Dout (pc_mux_s)
  );

  // Load the selected PC only when the control unit enables it, otherwise hold
  always_comb begin
    if (bus.PC_LdEn) begin
      pc_d = pc_mux_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register; reset dominates all load controls
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Word address drops the byte offset and wraps above the memory size
  instr_rom #(
    .ADDR_BITS (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk   (Clk),
    .rst_n (Reset),
    .addr  (pc_q[ADDR_BITS+1:2]),
    .dout  (instr_s)
  );

  assign bus.PC    = pc_q;
  assign bus.Instr = instr_s;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; image word k = 0xA000_0000 + k.
module tb_instr_fetch_unit;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .ADDR_BITS (10),
    .INIT_FILE ("")
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset        = 1'b0;
    bus.PC_LdEn  = 1'b0;
    bus.PC_Sel   = 1'b0;
    bus.PC_Immed = 32'h0;
    #1;
    for (int k = 0; k < 1024; k++) begin
      dut.u_rom.mem[k] = 32'hA000_0000 + 32'(k);
    end
    #1;
    check("reset_pc", bus.PC, 32'h0);
    check("reset_instr", bus.Instr, 32'h0);

    // Run sequentially up to PC = 0x40
    @(negedge Clk);
    Reset       = 1'b1;
    bus.PC_LdEn = 1'b1;
    for (int n = 0; n < 16; n++) step();
    check("run_pc40", bus.PC, 32'h0000_0040);
    check("run_instr15", bus.Instr, 32'hA000_000F);

    // 1. Asynchronous reset mid-run, no clock edge in between
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst_pc", bus.PC, 32'h0);
    check("async_rst_instr", bus.Instr, 32'h0);
    #1;
    Reset = 1'b1;
    step();
    check("rel1_pc", bus.PC, 32'h0000_0004);
    check("rel1_instr", bus.Instr, 32'hA000_0000);
    step();
    check("rel2_pc", bus.PC, 32'h0000_0008);
    check("rel2_instr", bus.Instr, 32'hA000_0001);

    // 2. Forward branch
    bus.PC_Sel   = 1'b1;
    bus.PC_Immed = 32'h0000_0010;
    step();
    check("br_pc", bus.PC, 32'h0000_001C);
    check("br_instr", bus.Instr, 32'hA000_0002);
    bus.PC_Sel = 1'b0;
    step();
    check("br_next_pc", bus.PC, 32'h0000_0020);
    check("br_target_instr", bus.Instr, 32'hA000_0007);

    // 3. Negative offset, then branch-to-self
    bus.PC_Sel   = 1'b1;
    bus.PC_Immed = 32'hFFFF_FFF0;
    step();
    check("neg_pc", bus.PC, 32'h0000_0014);
    check("neg_instr", bus.Instr, 32'hA000_0008);
    bus.PC_Immed = 32'hFFFF_FFFC;
    for (int n = 0; n < 3; n++) begin
      step();
      check("self_pc", bus.PC, 32'h0000_0014);
      check("self_instr", bus.Instr, 32'hA000_0005);
    end

    // 4. Stall at PC = 0x30
    bus.PC_Immed = 32'h0000_0018;
    step();
    check("to30_pc", bus.PC, 32'h0000_0030);
    bus.PC_LdEn = 1'b0;
    bus.PC_Sel  = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      check("stall_pc", bus.PC, 32'h0000_0030);
      check("stall_instr", bus.Instr, 32'hA000_000C);
    end

    // 5. Address wrap past 4 KiB
    bus.PC_LdEn  = 1'b1;
    bus.PC_Sel   = 1'b1;
    bus.PC_Immed = 32'h0000_0FC8;
    step();
    check("tofc_pc", bus.PC, 32'h0000_0FFC);
    bus.PC_Sel = 1'b0;
    step();
    check("wrap_pc", bus.PC, 32'h0000_1000);
    check("last_word_instr", bus.Instr, 32'hA000_03FF);
    step();
    check("wrap2_pc", bus.PC, 32'h0000_1004);
    check("wrap_instr", bus.Instr, 32'hA000_0000);

    // Misaligned PC reads the containing word
    bus.PC_Sel   = 1'b1;
    bus.PC_Immed = 32'h0000_0001;
    step();
    check("mis_pc", bus.PC, 32'h0000_1009);
    bus.PC_Sel = 1'b0;
    step();
    check("mis2_pc", bus.PC, 32'h0000_100D);
    check("mis_instr", bus.Instr, 32'hA000_0002);

    // 6. Reset dominates load/select over several edges
    bus.PC_Sel   = 1'b1;
    bus.PC_Immed = 32'h0000_0010;
    Reset        = 1'b0;
    #1;
    check("rprio_pc0", bus.PC, 32'h0);
    check("rprio_instr0", bus.Instr, 32'h0);
    for (int n = 0; n < 3; n++) begin
      step();
      check("rprio_pc", bus.PC, 32'h0);
      check("rprio_instr", bus.Instr, 32'h0);
    end
    Reset = 1'b1;
    step();
    check("rprio_rel_pc", bus.PC, 32'h0000_0014);
    check("rprio_rel_instr", bus.Instr, 32'hA000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit
